hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 16-bit pipelined CPU. It sits beside the register-read stage and shadows the back-end stages (execute through writeback) with a small scoreboard of in-flight destination registers. Each cycle it selects an operand forwarding source, raises a load-use stall and inserts a bubble, or squashes the register-read instruction on a taken-branch flush. It replaces fixed 4-stage forwarding detection with depth- and latency-generic logic, and adds stall and flush support plus performance counters.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_src_match.sv | 35 +++
 rtl/hazard_ctrl.sv | 87 ++++++++
 tb/tb_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard entry type, forwarding constant and readiness helper
package hazard_pkg;
    localparam int FWD_RF = 0;
    localparam int DST_W  = 8;
    typedef struct packed {
        logic             v;
        logic [DST_W-1:0] dst;
        logic             wr;
        logic             ld;
    } sb_entry_t;
    function automatic int rdy_stage(input logic ld, input int ld_rdy, input int alu_rdy);
        return ld ? ld_rdy : alu_rdy;
    endfunction
endpackage

// File: rtl/hazard_src_match.sv
// hazard_src_match: youngest-producer lookup for one source operand
// sb_i: scoreboard (index 0 = back stage 1); src_i/use_i: operand;
// match_o: a producer is in flight; kmin_o: its stage; ready_o: its result is forwardable
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int NUM_BACK = 2,
    parameter int ALU_RDY  = 1,
    parameter int LD_RDY   = 2,
    parameter int REG_W    = 3,
    parameter int SEL_W    = 2
) (
    input  sb_entry_t [NUM_BACK-1:0] sb_i,
    input  logic [REG_W-1:0]         src_i,
    input  logic                     use_i,
    output logic                     match_o,
    output logic [SEL_W-1:0]         kmin_o,
    output logic                     ready_o
);
    logic ld_hit;
    // scan oldest to youngest so the lowest matching stage is the one left standing
    always_comb begin
        match_o = 1'b0;
        kmin_o  = '0;
        ld_hit  = 1'b0;
        for (int k = NUM_BACK - 1; k >= 0; k--) begin
            if (use_i && sb_i[k].v && sb_i[k].wr && sb_i[k].dst == DST_W'(src_i)) begin
                match_o = 1'b1;
                kmin_o  = SEL_W'(k + 1);
                ld_hit  = sb_i[k].ld;
            end
        end
    end
    assign ready_o = match_o && (int'(kmin_o) >= rdy_stage(ld_hit, LD_RDY, ALU_RDY));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based forwarding, load-use stall and flush control
// inputs: clk, reset, i_dec_* (register-read instruction), i_flush (kill it);
// outputs: o_issue, o_stall, o_fwd_sel_a/b (0 = regfile, k = back stage k),
// o_busy (pending-write bitmap), o_stall_cnt/o_flush_cnt (saturating)
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int NUM_BACK = 2,
    parameter int ALU_RDY  = 1,
    parameter int LD_RDY   = 2,
    parameter int CNT_W    = 16,
    localparam int REG_W   = $clog2(NUM_REGS),
    localparam int SEL_W   = $clog2(NUM_BACK + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_dec_valid,
    input  logic [REG_W-1:0] i_dec_src_a,
    input  logic [REG_W-1:0] i_dec_src_b,
    input  logic             i_dec_use_a,
    input  logic             i_dec_use_b,
    input  logic [REG_W-1:0] i_dec_dst,
    input  logic             i_dec_wr,
    input  logic             i_dec_is_load,
    input  logic             i_flush,
    output logic             o_issue,
    output logic             o_stall,
    output logic [SEL_W-1:0] o_fwd_sel_a,
    output logic [SEL_W-1:0] o_fwd_sel_b,
    output logic [NUM_REGS-1:0] o_busy,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);
    sb_entry_t [NUM_BACK-1:0] sb_q, sb_d;
    sb_entry_t dec;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic match_a, ready_a, match_b, ready_b, hazard;
    logic [SEL_W-1:0] kmin_a, kmin_b;

    hazard_src_match #(.NUM_BACK(NUM_BACK), .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY),
                       .REG_W(REG_W), .SEL_W(SEL_W)) u_match_a (
        .sb_i(sb_q), .src_i(i_dec_src_a), .use_i(i_dec_use_a),
        .match_o(match_a), .kmin_o(kmin_a), .ready_o(ready_a)
    );
    hazard_src_match #(.NUM_BACK(NUM_BACK), .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY),
                       .REG_W(REG_W), .SEL_W(SEL_W)) u_match_b (
        .sb_i(sb_q), .src_i(i_dec_src_b), .use_i(i_dec_use_b),
        .match_o(match_b), .kmin_o(kmin_b), .ready_o(ready_b)
    );

    assign hazard      = (match_a && !ready_a) || (match_b && !ready_b);
    assign o_stall     = i_dec_valid && !i_flush && hazard;
    assign o_issue     = i_dec_valid && !i_flush && !hazard;
    assign o_fwd_sel_a = ready_a ? kmin_a : SEL_W'(FWD_RF);
    assign o_fwd_sel_b = ready_b ? kmin_b : SEL_W'(FWD_RF);
    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
    assign dec = '{v: 1'b1, dst: DST_W'(i_dec_dst), wr: i_dec_wr, ld: i_dec_is_load};

    always_comb begin
        o_busy = '0;
        for (int k = 0; k < NUM_BACK; k++)
            if (sb_q[k].v && sb_q[k].wr) o_busy[sb_q[k].dst[REG_W-1:0]] = 1'b1;
    end

    // back stages always advance; a stall or flush only turns stage 1 into a bubble
    always_comb begin
        sb_d    = sb_q;
        sb_d[0] = o_issue ? dec : '0;
        for (int k = 1; k < NUM_BACK; k++) sb_d[k] = sb_q[k-1];
        stall_cnt_d = (o_stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (i_flush && i_dec_valid && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed table, corner sequences and random run against an issue-history model
module tb_hazard_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, v, f, ua, ub, wr, ld;
    logic [2:0] sa, sb, dst;

    logic iss0, st0, iss1, st1;
    logic [1:0] sela0, selb0, sela1, selb1;
    logic [7:0] bz0, bz1;
    logic [15:0] sc0, fc0;
    logic [3:0] sc1, fc1;

    hazard_ctrl d0 (
        .clk(clk), .reset(rst), .i_dec_valid(v), .i_dec_src_a(sa), .i_dec_src_b(sb),
        .i_dec_use_a(ua), .i_dec_use_b(ub), .i_dec_dst(dst), .i_dec_wr(wr),
        .i_dec_is_load(ld), .i_flush(f), .o_issue(iss0), .o_stall(st0),
        .o_fwd_sel_a(sela0), .o_fwd_sel_b(selb0), .o_busy(bz0),
        .o_stall_cnt(sc0), .o_flush_cnt(fc0)
    );
    hazard_ctrl #(.NUM_BACK(3), .ALU_RDY(2), .LD_RDY(3), .CNT_W(4)) d1 (
        .clk(clk), .reset(rst), .i_dec_valid(v), .i_dec_src_a(sa), .i_dec_src_b(sb),
        .i_dec_use_a(ua), .i_dec_use_b(ub), .i_dec_dst(dst), .i_dec_wr(wr),
        .i_dec_is_load(ld), .i_flush(f), .o_issue(iss1), .o_stall(st1),
        .o_fwd_sel_a(sela1), .o_fwd_sel_b(selb1), .o_busy(bz1),
        .o_stall_cnt(sc1), .o_flush_cnt(fc1)
    );

    int n_tests = 0;
    int n_fail = 0;

    // model: every issued instruction is remembered with its issue cycle;
    // an instruction issued in cycle c sits in back stage now-c
    typedef struct {int cyc; int dst; bit wr; bit ld;} rec_t;
    rec_t rec [2][64];
    int now = 0;
    int nb [2] = '{2, 3};
    int ldr [2] = '{2, 3};
    int alr [2] = '{1, 2};
    int cmax [2] = '{65535, 15};
    int esc [2] = '{0, 0};
    int efc [2] = '{0, 0};

    typedef struct {
        bit v, f; int sa; bit ua; int sb; bit ub; int dst; bit wr, ld;
        bit e_iss, e_st; int e_sa, e_sb, e_bz;
    } vec_t;
    vec_t tbl [24];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void msel(input int m, input int src, input bit u, output int sel, output bit haz);
        bit found = 0;
        sel = 0;
        haz = 0;
        for (int k = 1; k <= nb[m]; k++) begin
            int c;
            c = now - k;
            if (!found && u && c >= 0 && rec[m][c % 64].cyc == c && rec[m][c % 64].wr
                && rec[m][c % 64].dst == src) begin
                found = 1;
                if (k >= (rec[m][c % 64].ld ? ldr[m] : alr[m])) sel = k;
                else haz = 1;
            end
        end
    endfunction

    function automatic int mbusy(input int m);
        int b = 0;
        for (int k = 1; k <= nb[m]; k++) begin
            int c;
            c = now - k;
            if (c >= 0 && rec[m][c % 64].cyc == c && rec[m][c % 64].wr) b |= (1 << rec[m][c % 64].dst);
        end
        return b;
    endfunction

    task automatic chk_m(input int m, input int iss, input int st, input int a, input int b,
                         input int bz, input int sc, input int fc);
        int ea, eb;
        bit ha, hb;
        msel(m, int'(sa), ua, ea, ha);
        msel(m, int'(sb), ub, eb, hb);
        chk($sformatf("m%0d issue", m), iss, int'(v && !f && !(ha || hb)));
        chk($sformatf("m%0d stall", m), st, int'(v && !f && (ha || hb)));
        chk($sformatf("m%0d sel_a", m), a, ea);
        chk($sformatf("m%0d sel_b", m), b, eb);
        chk($sformatf("m%0d busy", m), bz, mbusy(m));
        chk($sformatf("m%0d stall_cnt", m), sc, esc[m]);
        chk($sformatf("m%0d flush_cnt", m), fc, efc[m]);
    endtask

    task automatic upd(input int m);
        int ea, eb;
        bit ha, hb;
        msel(m, int'(sa), ua, ea, ha);
        msel(m, int'(sb), ub, eb, hb);
        if (rst) begin
            for (int i = 0; i < 64; i++) rec[m][i].cyc = -1;
            esc[m] = 0;
            efc[m] = 0;
        end else begin
            if (v && !f && !(ha || hb)) rec[m][now % 64] = '{now, int'(dst), wr, ld};
            if (v && !f && (ha || hb) && esc[m] < cmax[m]) esc[m]++;
            if (v && f && efc[m] < cmax[m]) efc[m]++;
        end
    endtask

    task automatic fin();
        chk_m(0, int'(iss0), int'(st0), int'(sela0), int'(selb0), int'(bz0), int'(sc0), int'(fc0));
        chk_m(1, int'(iss1), int'(st1), int'(sela1), int'(selb1), int'(bz1), int'(sc1), int'(fc1));
        upd(0);
        upd(1);
        now++;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        fin();
    endtask

    task automatic drv(input bit vv, input bit ff, input int a, input bit ia, input int b, input bit ib,
                       input int d, input bit w, input bit l);
        v = vv; f = ff; sa = 3'(a); ua = ia; sb = 3'(b); ub = ib; dst = 3'(d); wr = w; ld = l;
    endtask

    initial begin
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 64; i++) rec[m][i] = '{-1, 0, 0, 0};
        tbl[0]  = '{1,0,0,0,0,0,1,1,0, 1,0,0,0,8'h00};
        tbl[1]  = '{1,0,1,1,3,1,2,1,0, 1,0,1,0,8'h02};
        tbl[2]  = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h06};
        tbl[3]  = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h04};
        tbl[4]  = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h00};
        tbl[5]  = '{1,0,0,0,0,0,1,1,1, 1,0,0,0,8'h00};
        tbl[6]  = '{1,0,1,1,1,1,2,1,0, 0,1,0,0,8'h02};
        tbl[7]  = '{1,0,1,1,1,1,2,1,0, 1,0,2,2,8'h02};
        tbl[8]  = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h04};
        tbl[9]  = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h04};
        tbl[10] = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h00};
        tbl[11] = '{1,0,0,0,0,0,3,1,0, 1,0,0,0,8'h00};
        tbl[12] = '{1,0,0,0,0,0,3,1,0, 1,0,0,0,8'h08};
        tbl[13] = '{1,0,3,1,0,0,4,0,0, 1,0,1,0,8'h08};
        tbl[14] = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h08};
        tbl[15] = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h00};
        tbl[16] = '{1,0,0,0,0,0,5,1,1, 1,0,0,0,8'h00};
        tbl[17] = '{1,1,5,1,0,0,6,1,0, 0,0,0,0,8'h20};
        tbl[18] = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h20};
        tbl[19] = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h00};
        tbl[20] = '{1,0,0,0,0,0,7,1,1, 1,0,0,0,8'h00};
        tbl[21] = '{0,0,7,1,7,1,0,0,0, 0,0,0,0,8'h80};
        tbl[22] = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h80};
        tbl[23] = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h00};

        rst = 1'b1;
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        upd(0);
        upd(1);
        now++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst stall", int'(st0), 0);
            chk("rst busy", int'(bz0), 0);
            chk("rst stall_cnt", int'(sc0), 0);
            chk("rst flush_cnt", int'(fc0), 0);
            fin();
        end
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            drv(tbl[i].v, tbl[i].f, tbl[i].sa, tbl[i].ua, tbl[i].sb, tbl[i].ub, tbl[i].dst, tbl[i].wr, tbl[i].ld);
            @(negedge clk);
            chk($sformatf("tbl%0d issue", i), int'(iss0), int'(tbl[i].e_iss));
            chk($sformatf("tbl%0d stall", i), int'(st0), int'(tbl[i].e_st));
            chk($sformatf("tbl%0d sel_a", i), int'(sela0), tbl[i].e_sa);
            chk($sformatf("tbl%0d sel_b", i), int'(selb0), tbl[i].e_sb);
            chk($sformatf("tbl%0d busy", i), int'(bz0), tbl[i].e_bz);
            fin();
        end
        @(negedge clk);
        chk("tbl stall_cnt", int'(sc0), 1);
        chk("tbl flush_cnt", int'(fc0), 1);
        fin();

        rst = 1'b1;
        step();
        rst = 1'b0;
        drv(1, 0, 0, 0, 0, 0, 4, 1, 1);
        step();
        drv(1, 0, 4, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("deep stall", int'(st1), 1);
            chk("deep issue", int'(iss1), 0);
            fin();
        end
        @(negedge clk);
        chk("deep issue after", int'(iss1), 1);
        chk("deep sel_a", int'(sela1), 3);
        fin();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("deep stall_cnt", int'(sc1), 2);
        fin();
        for (int j = 0; j < 11; j++) begin
            drv(1, 0, 0, 0, 0, 0, 4, 1, 1);
            step();
            drv(1, 0, 4, 1, 4, 1, 0, 0, 0);
            for (int i = 0; i < 3; i++) step();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat stall_cnt", int'(sc1), 15);
        fin();

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(63) == 0);
            drv($urandom_range(3) != 0, $urandom_range(7) == 0, $urandom_range(7), $urandom_range(1) == 1,
                $urandom_range(7), $urandom_range(1) == 1, $urandom_range(7), $urandom_range(3) != 0,
                $urandom_range(2) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
